// File: rtl/writeback_arbiter.sv
// writeback_arbiter
//   Collects results from three execution units (alu=0, lsu=1, br=2), buffers
//   each in its own small FIFO, and retires up to two FIFO heads per cycle onto
//   the two register-file write ports, rotating priority round-robin.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   flush_i               empties all FIFOs and kills the next wb cycle
//   <u>_in_*_i / _o       valid/ready result channel per unit (dest, data, rob)
//   wb<k>_*_o             write port k: valid, dest, data, rob
//   stall_cnt_o           backpressure cycle counter (only with WB_STALL_CNT_EN)
//
// Configuration macro: WB_STALL_CNT_EN
module writeback_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int PREG_WIDTH = 7,
  parameter int ROB_WIDTH  = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush_i,
  input  logic                  alu_in_valid_i,
  output logic                  alu_in_ready_o,
  input  logic [PREG_WIDTH-1:0] alu_in_dest_i,
  input  logic [DATA_WIDTH-1:0] alu_in_data_i,
  input  logic [ROB_WIDTH-1:0]  alu_in_rob_i,
  input  logic                  lsu_in_valid_i,
  output logic                  lsu_in_ready_o,
  input  logic [PREG_WIDTH-1:0] lsu_in_dest_i,
  input  logic [DATA_WIDTH-1:0] lsu_in_data_i,
  input  logic [ROB_WIDTH-1:0]  lsu_in_rob_i,
  input  logic                  br_in_valid_i,
  output logic                  br_in_ready_o,
  input  logic [PREG_WIDTH-1:0] br_in_dest_i,
  input  logic [DATA_WIDTH-1:0] br_in_data_i,
  input  logic [ROB_WIDTH-1:0]  br_in_rob_i,
  output logic                  wb0_valid_o,
  output logic [PREG_WIDTH-1:0] wb0_dest_o,
  output logic [DATA_WIDTH-1:0] wb0_data_o,
  output logic [ROB_WIDTH-1:0]  wb0_rob_o,
  output logic                  wb1_valid_o,
  output logic [PREG_WIDTH-1:0] wb1_dest_o,
  output logic [DATA_WIDTH-1:0] wb1_data_o,
  output logic [ROB_WIDTH-1:0]  wb1_rob_o
`ifdef WB_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);

  localparam int NCH   = 3;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  function automatic logic [1:0] next_ch(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  logic [NCH-1:0]        in_valid;
  logic [NCH-1:0]        in_ready;
  logic [NCH-1:0]        enq;
  logic [NCH-1:0]        deq;
  logic [NCH-1:0]        nonempty;
  logic [PREG_WIDTH-1:0] in_dest [NCH];
  logic [DATA_WIDTH-1:0] in_data [NCH];
  logic [ROB_WIDTH-1:0]  in_rob  [NCH];

  logic [PREG_WIDTH-1:0] dest_mem_q [NCH][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [NCH][FIFO_DEPTH];
  logic [ROB_WIDTH-1:0]  rob_mem_q  [NCH][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q   [NCH];
  logic [PTR_W-1:0]      rd_ptr_q   [NCH];
  logic [CNT_W-1:0]      count_q    [NCH];

  logic [PREG_WIDTH-1:0] head_dest [NCH];
  logic [DATA_WIDTH-1:0] head_data [NCH];
  logic [ROB_WIDTH-1:0]  head_rob  [NCH];

  logic [1:0] rr_q, rr_d;
  logic       g0_vld, g1_vld;
  logic [1:0] g0_ch, g1_ch;

  logic                  wb0_valid_q, wb1_valid_q;
  logic [PREG_WIDTH-1:0] wb0_dest_q, wb1_dest_q, w0_dest, w1_dest;
  logic [DATA_WIDTH-1:0] wb0_data_q, wb1_data_q, w0_data, w1_data;
  logic [ROB_WIDTH-1:0]  wb0_rob_q, wb1_rob_q, w0_rob, w1_rob;

  assign in_valid   = {br_in_valid_i, lsu_in_valid_i, alu_in_valid_i};
  assign in_dest[0] = alu_in_dest_i;
  assign in_dest[1] = lsu_in_dest_i;
  assign in_dest[2] = br_in_dest_i;
  assign in_data[0] = alu_in_data_i;
  assign in_data[1] = lsu_in_data_i;
  assign in_data[2] = br_in_data_i;
  assign in_rob[0]  = alu_in_rob_i;
  assign in_rob[1]  = lsu_in_rob_i;
  assign in_rob[2]  = br_in_rob_i;

  always_comb begin
    in_ready = '0;
    enq      = '0;
    nonempty = '0;
    for (int c = 0; c < NCH; c++) begin
      // Ready looks only at registered occupancy, so a same-cycle dequeue
      // never opens up a slot early.
      in_ready[c]  = !reset && !flush_i && (count_q[c] != CNT_W'(FIFO_DEPTH));
      // Writes to p0 are architecturally void: accept but do not buffer.
      enq[c]       = in_valid[c] && in_ready[c] && (in_dest[c] != '0);
      nonempty[c]  = (count_q[c] != '0);
      head_dest[c] = dest_mem_q[c][rd_ptr_q[c]];
      head_data[c] = data_mem_q[c][rd_ptr_q[c]];
      head_rob[c]  = rob_mem_q[c][rd_ptr_q[c]];
    end
  end

  assign alu_in_ready_o = in_ready[0];
  assign lsu_in_ready_o = in_ready[1];
  assign br_in_ready_o  = in_ready[2];

  // Round-robin scan from rr; first hit goes to wb0, second to wb1.
  always_comb begin
    logic [1:0] ch;
    g0_vld = 1'b0;
    g1_vld = 1'b0;
    g0_ch  = 2'd0;
    g1_ch  = 2'd0;
    ch     = rr_q;
    for (int k = 0; k < NCH; k++) begin
      if (nonempty[ch] && !flush_i) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0_ch  = ch;
        end else if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_ch  = ch;
        end
      end
      ch = next_ch(ch);
    end

    if (g1_vld)      rr_d = next_ch(g1_ch);
    else if (g0_vld) rr_d = next_ch(g0_ch);
    else             rr_d = rr_q;

    deq     = '0;
    w0_dest = head_dest[2];
    w0_data = head_data[2];
    w0_rob  = head_rob[2];
    w1_dest = head_dest[2];
    w1_data = head_data[2];
    w1_rob  = head_rob[2];
    for (int c = 0; c < NCH; c++) begin
      deq[c] = (g0_vld && g0_ch == 2'(c)) || (g1_vld && g1_ch == 2'(c));
      if (g0_ch == 2'(c)) begin
        w0_dest = head_dest[c];
        w0_data = head_data[c];
        w0_rob  = head_rob[c];
      end
      if (g1_ch == 2'(c)) begin
        w1_dest = head_dest[c];
        w1_data = head_data[c];
        w1_rob  = head_rob[c];
      end
    end
  end

  // Storage needs no reset: occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (enq[c]) begin
        dest_mem_q[c][wr_ptr_q[c]] <= in_dest[c];
        data_mem_q[c][wr_ptr_q[c]] <= in_data[c];
        rob_mem_q[c][wr_ptr_q[c]]  <= in_rob[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        count_q[c]  <= '0;
      end
      rr_q        <= 2'd0;
      wb0_valid_q <= 1'b0;
      wb0_dest_q  <= '0;
      wb0_data_q  <= '0;
      wb0_rob_q   <= '0;
      wb1_valid_q <= 1'b0;
      wb1_dest_q  <= '0;
      wb1_data_q  <= '0;
      wb1_rob_q   <= '0;
    end else if (flush_i) begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        count_q[c]  <= '0;
      end
      wb0_valid_q <= 1'b0;
      wb1_valid_q <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (enq[c]) wr_ptr_q[c] <= wr_ptr_q[c] + PTR_W'(1);
        if (deq[c]) rd_ptr_q[c] <= rd_ptr_q[c] + PTR_W'(1);
        count_q[c] <= count_q[c] + CNT_W'(enq[c]) - CNT_W'(deq[c]);
      end
      rr_q        <= rr_d;
      wb0_valid_q <= g0_vld;
      wb1_valid_q <= g1_vld;
      if (g0_vld) begin
        wb0_dest_q <= w0_dest;
        wb0_data_q <= w0_data;
        wb0_rob_q  <= w0_rob;
      end
      if (g1_vld) begin
        wb1_dest_q <= w1_dest;
        wb1_data_q <= w1_data;
        wb1_rob_q  <= w1_rob;
      end
    end
  end

  assign wb0_valid_o = wb0_valid_q;
  assign wb0_dest_o  = wb0_dest_q;
  assign wb0_data_o  = wb0_data_q;
  assign wb0_rob_o   = wb0_rob_q;
  assign wb1_valid_o = wb1_valid_q;
  assign wb1_dest_o  = wb1_dest_q;
  assign wb1_data_o  = wb1_data_q;
  assign wb1_rob_o   = wb1_rob_q;

`ifdef WB_STALL_CNT_EN
  logic        any_stall;
  logic [31:0] stall_cnt_q;

  assign any_stall = |(in_valid & ~in_ready);

  // Flush leaves the counter alone; it saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset)                                   stall_cnt_q <= '0;
    else if (any_stall && stall_cnt_q != '1)     stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, result data width.
REQ-002 Parameter PREG_WIDTH, default 7, physical register tag width.
REQ-003 Parameter ROB_WIDTH, default 5, ROB index width.
REQ-004 Parameter FIFO_DEPTH, default 2, per-channel buffer depth; power of two, at least 2.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  synchronous pipeline flush (mispredict/exception).
REQ-008 <u>_in_valid  input  1  result offered by unit u; u in {alu, lsu, br}, one port per unit.
REQ-009 <u>_in_ready  output  1  channel u accepts this cycle.
REQ-010 <u>_in_dest  input  PREG_WIDTH  destination physical register.
REQ-011 <u>_in_data  input  DATA_WIDTH  result value.
REQ-012 <u>_in_rob  input  ROB_WIDTH  ROB index for completion marking.
REQ-013 wb<k>_valid  output  1  register file write enable for write port k; k in {0,1}.
REQ-014 wb<k>_dest  output  PREG_WIDTH  write address for port k.
REQ-015 wb<k>_data  output  DATA_WIDTH  write data for port k.
REQ-016 wb<k>_rob  output  ROB_WIDTH  ROB index for port k.
REQ-017 stall_cnt  output  32  backpressure cycle count; present only under WB_STALL_CNT_EN.

Function
REQ-018 Each channel SHALL have a FIFO of FIFO_DEPTH entries {dest, data, rob}, with wrap-around read and write pointers and an occupancy count.
REQ-019 <u>_in_ready SHALL be 1 iff the channel FIFO is not full and flush is 0; it SHALL NOT depend on <u>_in_valid or on a same-cycle dequeue.
REQ-020 A transfer occurs when valid and ready are both 1.
REQ-021 A transfer with dest==0 SHALL be accepted and discarded, never enqueued.
REQ-022 Each cycle, the arbiter SHALL grant up to two non-empty FIFO heads, scanning in round-robin order starting at pointer rr, with rr in {0=alu, 1=lsu, 2=br}.
REQ-023 The first grant SHALL go to wb0 and the second to wb1; wb1 SHALL never be valid while wb0 is invalid.
REQ-024 rr SHALL advance to the channel after the last granted channel, modulo 3, and SHALL be unchanged when there are no grants.
REQ-025 Granted heads SHALL be dequeued and registered onto the wb ports at the same edge, giving a minimum input-to-wb latency of 2 cycles (accepted at edge E, wb valid after edge E+1).
REQ-026 With no grant, wb<k>_valid SHALL be 0 the next cycle; wb<k>_dest, wb<k>_data and wb<k>_rob SHALL hold their previous values.
REQ-027 An enqueue and a dequeue on the same channel in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-028 Entries SHALL leave each channel in arrival order; no entry is lost or duplicated.
REQ-029 When flush is 1, all FIFOs SHALL be emptied and wb0_valid/wb1_valid SHALL be 0 the following cycle; no grant is made in the flush cycle; rr is preserved.

Reset
REQ-030 While reset is 1, all FIFOs SHALL be empty and pointers zero, rr SHALL be 0, wb<k>_valid/dest/data/rob SHALL be 0, and stall_cnt SHALL be 0.
REQ-031 <u>_in_ready SHALL be 0 during reset.
REQ-032 Reset SHALL take priority over flush and over any in-flight transfer.
REQ-033 Reset asserted mid-operation SHALL discard all buffered entries.

Configuration
REQ-034 Macro WB_STALL_CNT_EN: when defined, stall_cnt SHALL increment by 1 each cycle in which any channel has in_valid=1 and in_ready=0, saturating at 0xFFFFFFFF; reset clears it and flush does not.
REQ-035 Without WB_STALL_CNT_EN, the stall_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-036 After reset, ALU offers dest=5, data=0xDEADBEEF, rob=3 -> two cycles later wb0 valid with 5/0xDEADBEEF/3; wb1_valid=0.
REQ-037 All three units offer in one cycle with rr=0 -> wb0=alu, wb1=lsu; br appears on wb0 the next cycle; rr ends at 0.
REQ-038 LSU offers dest=0, data=0x1 -> accepted (ready=1), and no wb valid ever results.
REQ-039 ALU held valid for 4 consecutive cycles with FIFO_DEPTH=2 while LSU and BR saturate the ports -> alu_in_ready drops at full, no entry is lost, and alu entries retire in order; with WB_STALL_CNT_EN, stall_cnt counts exactly the cycles with ready=0.
REQ-040 Fill all FIFOs, then assert flush for 1 cycle -> the next cycle both wb valids are 0, all readies are 1, and no stale entry ever appears.
REQ-041 Assert reset mid-stream with entries buffered -> all outputs read 0, rr=0, and post-reset traffic is unaffected by pre-reset entries.
